// File: rtl/input_fifo.sv
// Router input buffer: first-word-fall-through flit FIFO with overflow
// reporting and a header/payload/tail packet-ordering checker.
module input_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  read_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [2:0]            flit_id,
    output logic [3:0]            dst_addr,
    output logic                  empty,
    output logic                  full,
    output logic                  overflow,
    output logic                  proto_err
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    localparam logic [2:0] FLIT_HEADER  = 3'b001;
    localparam logic [2:0] FLIT_PAYLOAD = 3'b010;
    localparam logic [2:0] FLIT_TAIL    = 3'b100;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_IN_PKT = 1'b1
    } pkt_state_e;

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q,  count_d;
    pkt_state_e            state_q,  state_d;
    logic                  overflow_q, overflow_d;
    logic                  proto_err_q, proto_err_d;

    logic                  empty_s;
    logic                  full_s;
    logic                  wr_accept_s;
    logic                  rd_accept_s;
    logic [2:0]            in_type_s;

    assign empty_s     = (count_q == CNT_W'(0));
    assign full_s      = (count_q == CNT_W'(FIFO_DEPTH));
    assign wr_accept_s = valid_in & ~full_s;
    assign rd_accept_s = read_en & ~empty_s;
    assign in_type_s   = data_in[31:29];

    // Pointer and occupancy next-state; both pointers wrap naturally at the power-of-two depth.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = valid_in & full_s;
        if (wr_accept_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (rd_accept_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({wr_accept_s, rd_accept_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Packet-ordering checker: only flits actually stored advance it or flag errors.
    always_comb begin
        state_d     = state_q;
        proto_err_d = 1'b0;
        if (wr_accept_s) begin
            case (in_type_s)
                FLIT_HEADER: begin
                    if (state_q == ST_IDLE) begin
                        state_d = ST_IN_PKT;
                    end else begin
                        proto_err_d = 1'b1;
                    end
                end
                FLIT_PAYLOAD: begin
                    if (state_q == ST_IDLE) begin
                        proto_err_d = 1'b1;
                    end else begin
                        state_d = ST_IN_PKT;
                    end
                end
                FLIT_TAIL: begin
                    if (state_q == ST_IDLE) begin
                        proto_err_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: proto_err_d = 1'b1;
            endcase
        end else begin
            state_d     = state_q;
            proto_err_d = 1'b0;
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= PTR_W'(0);
            rd_ptr_q    <= PTR_W'(0);
            count_q     <= CNT_W'(0);
            state_q     <= ST_IDLE;
            overflow_q  <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            overflow_q  <= overflow_d;
            proto_err_q <= proto_err_d;
        end
    end

    // Flit storage; contents deliberately survive reset, occupancy alone governs validity.
    always_ff @(posedge clk) begin
        if (!rst && wr_accept_s) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    assign data_out  = mem_q[rd_ptr_q];
    assign flit_id   = data_out[31:29];
    assign dst_addr  = data_out[7:4];
    assign empty     = empty_s;
    assign full      = full_s;
    assign overflow  = overflow_q;
    assign proto_err = proto_err_q;

endmodule
